ea_sequencer: RTL and testbench
===============================

// Module: ea_sequencer
// PURPOSE
//  Effective-address sequencer for memory-reference instructions (AND/TAD/ISZ/DCA/JMS/JMP).
//  Consumes the addressing-mode flags from the IR decoder (DIR, IND, PPIND, MP) plus IR/PCLATCHED.
//  Forms the page address, then fetches the indirect pointer and auto-increments it through the
//  memory port. Delivers the final 12-bit EA to the execute sequencer with a one-cycle EA_VALID strobe.
// PARAMETERS
//  WORD_W    12  data/address word width; only 12 is supported
//  FIELD_W   3   memory-field width; used only with EA_DF_EN
// PORTS
//  CLK        in   1   system clock; all state changes on the rising edge
//  RESET      in   1   asynchronous, active-high reset
//  START      in   1   one-cycle request to resolve the EA of the IR; ignored while BUSY=1
//  IR         in   12  current instruction word
//  PCLATCHED  in   12  address the instruction was fetched from
//  DIR        in   1   direct addressing (IR[8]=0)
//  IND        in   1   indirect addressing, not auto-index
//  PPIND      in   1   indirect through auto-index location 0010-0017
//  MP         in   1   current-page bit (IR[7])
//  MEM_REQ    out  1   memory request; held high until MEM_ACK is sampled high
//  MEM_WE     out  1   1=write, 0=read; stable while MEM_REQ=1
//  MEM_ADDR   out  12  memory address; stable while MEM_REQ=1
//  MEM_WDATA  out  12  write data; stable while MEM_REQ&MEM_WE
//  MEM_RDATA  in   12  read data; valid in the cycle MEM_ACK=1
//  MEM_ACK    in   1   transfer complete for the current request
//  EA         out  12  effective address; held until the next START is accepted
//  EA_VALID   out  1   one-cycle strobe: EA is final
//  BUSY       out  1   high from START acceptance until the cycle EA_VALID is asserted
// BEHAVIOUR
//  Reset values: MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, EA=0, EA_VALID=0, BUSY=0; state IDLE.
//  PA = MP ? {PCLATCHED[11:7],IR[6:0]} : {5'b0,IR[6:0]}; computed and latched when START is accepted.
//  Mode priority at START: PPIND > IND > DIR. If none is set (IR[8]=1 on IOT/OPR), treat as DIR.
//  States: IDLE, RD_PTR, WR_PTR, DONE.
//   IDLE   START & DIR-class -> DONE with EA<=PA. IND/PPIND -> RD_PTR, MEM_REQ=1, WE=0, ADDR=PA.
//   RD_PTR on MEM_ACK: IND: EA<=MEM_RDATA, go to DONE.
//          PPIND: PTR<=MEM_RDATA+1 (mod 4096; 7777->0000), go to WR_PTR, WE=1, ADDR=PA, WDATA=PTR.
//   WR_PTR on MEM_ACK: EA<=incremented pointer, go to DONE.
//   DONE   EA_VALID=1 for exactly one cycle, BUSY=0, go to IDLE.
//  MEM_REQ drops in the cycle after ACK. RD->WR are back-to-back: MEM_REQ may stay high, with WE rising.
//  Latency: direct START@n -> EA_VALID@n+1. Indirect: ACK@k -> EA_VALID@k+1.
//   Auto-index: read ACK@k -> write REQ@k+1; write ACK@j -> EA_VALID@j+1.
//  Wait states unbounded: stay in RD_PTR/WR_PTR while MEM_ACK=0. No timeout.
//  MEM_ACK while MEM_REQ=0 is ignored. START while BUSY is ignored (not queued).
//  START accepted in the DONE cycle? No: accepted only in IDLE, so minimum spacing is 2 cycles.
//  RESET mid-operation aborts immediately, including a pending write-back; all outputs go to reset values.
// CONFIGURATION
//  EA_DF_EN defined: adds inputs IF_IN[FIELD_W-1:0] and DF_IN[FIELD_W-1:0].
//   Adds outputs MEM_FIELD[FIELD_W-1:0] and EA_FIELD[FIELD_W-1:0] (both reset to 0).
//   Pointer read/write uses MEM_FIELD=IF_IN. EA_FIELD=DF_IN for IND/PPIND, IF_IN for DIR.
//   IF_IN and DF_IN are latched at START.
//  EA_DF_EN undefined: these ports do not exist; single 4K field.
// STRUCTURE
//  Shared package pdp8_pkg: WORD_W; state enum ea_state_t.
//   Constants AUTOIDX_LO=12'o0010, AUTOIDX_HI=12'o0017, PAGE_MASK=12'o7600.
//  One sub-module: ea_page_form (combinational PA from IR, PCLATCHED, MP); reused by the fetch path.
// TESTING
//  Direct, page zero: IR=1 0 0 0 0 1 0 1 (MP=0), START -> EA=0005 at next cycle, no MEM_REQ.
//  Direct, current page: MP=1, PCLATCHED=4210, IR[6:0]=0025 -> EA=4225, EA_VALID 1 cycle later.
//  Indirect: PA=0040, M[0040]=3456, 2 wait states -> one read, EA=3456 at ACK+1.
//  Auto-index: PA=0012, M[0012]=7777 -> read, then write 0000 to 0012, EA=0000.
//  Reset during WR_PTR with MEM_ACK=0 -> MEM_REQ=0 and BUSY=0 immediately.
//   Following START works normally, no stale EA_VALID.
//  START while BUSY, and spurious MEM_ACK in IDLE -> ignored; EA unchanged; one EA_VALID per accepted START.

Source files
------------

// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - shared word width, sequencer states and address constants
package pdp8_pkg;

  localparam int WORD_W = 12;

  // Auto-index locations: indirect references here post-increment the pointer.
  localparam logic [WORD_W-1:0] AUTOIDX_LO = 12'o0010;
  localparam logic [WORD_W-1:0] AUTOIDX_HI = 12'o0017;

  // Bits of an address that select the 128-word page.
  localparam logic [WORD_W-1:0] PAGE_MASK  = 12'o7600;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_PTR = 2'd1,
    WR_PTR = 2'd2,
    DONE   = 2'd3
  } ea_state_t;

endpackage

// File: rtl/ea_page_form.sv
// rtl/ea_page_form.sv - combinational page-address former for memory-reference instructions
//
// Ports:
//   i_ir         instruction word; only the 7-bit page offset IR[6:0] is used
//   i_pclatched  address the instruction was fetched from; supplies the page bits
//   i_mp         1 = current page, 0 = page zero
//   o_pa         page address
import pdp8_pkg::*;

module ea_page_form (
  input  logic [WORD_W-1:0] i_ir,
  input  logic [WORD_W-1:0] i_pclatched,
  input  logic              i_mp,
  output logic [WORD_W-1:0] o_pa
);

  logic [WORD_W-1:0] w_offset;
  logic              w_unused_bits;

  assign w_offset = {5'b0, i_ir[6:0]};
  assign o_pa     = i_mp ? ((i_pclatched & PAGE_MASK) | w_offset) : w_offset;

  // Opcode/mode bits and the in-page bits of the PC play no part in the page address.
  assign w_unused_bits = &{1'b0, i_ir[11:7], i_pclatched[6:0]};

endmodule

// File: rtl/ea_sequencer.sv
// rtl/ea_sequencer.sv - effective-address sequencer: page address, indirect fetch, auto-index write-back
//
// Optional feature macro: EA_DF_EN (adds memory-field ports i_if_in/i_df_in, o_mem_field/o_ea_field).
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_start                        one-cycle request, accepted only in IDLE
//   i_ir, i_pclatched              instruction word and its fetch address
//   i_dir, i_ind, i_ppind, i_mp    addressing-mode flags from the IR decoder
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_rdata/i_mem_ack   pointer memory port
//   o_ea, o_ea_valid               effective address and its one-cycle strobe
//   o_busy                         high while a pointer access is in progress
import pdp8_pkg::*;

module ea_sequencer #(
  parameter int WORD_W = pdp8_pkg::WORD_W
`ifdef EA_DF_EN
  ,
  parameter int FIELD_W = 3
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [WORD_W-1:0] i_ir,
  input  logic [WORD_W-1:0] i_pclatched,
  input  logic              i_dir,
  input  logic              i_ind,
  input  logic              i_ppind,
  input  logic              i_mp,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [WORD_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  input  logic [WORD_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
`ifdef EA_DF_EN
  input  logic [FIELD_W-1:0] i_if_in,
  input  logic [FIELD_W-1:0] i_df_in,
  output logic [FIELD_W-1:0] o_mem_field,
  output logic [FIELD_W-1:0] o_ea_field,
`endif
  output logic [WORD_W-1:0] o_ea,
  output logic              o_ea_valid,
  output logic              o_busy
);

  ea_state_t         r_state, w_state_nxt;
  logic              r_auto, w_auto_nxt;
  logic              r_req, w_req_nxt;
  logic              r_we, w_we_nxt;
  logic [WORD_W-1:0] r_addr, w_addr_nxt;
  logic [WORD_W-1:0] r_wdata, w_wdata_nxt;
  logic [WORD_W-1:0] r_ea, w_ea_nxt;
  logic              r_valid, w_valid_nxt;
  logic [WORD_W-1:0] w_pa;
  logic              w_unused_dir;

`ifdef EA_DF_EN
  logic [FIELD_W-1:0] r_df, w_df_nxt;
  logic [FIELD_W-1:0] r_mem_field, w_mem_field_nxt;
  logic [FIELD_W-1:0] r_ea_field, w_ea_field_nxt;
`endif

  ea_page_form u_page_form (
    .i_ir        (i_ir),
    .i_pclatched (i_pclatched),
    .i_mp        (i_mp),
    .o_pa        (w_pa)
  );

  // Anything that is neither IND nor PPIND resolves as direct, so DIR itself is never consulted.
  assign w_unused_dir = &{1'b0, i_dir};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_auto      <= 1'b0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ea        <= '0;
      r_valid     <= 1'b0;
`ifdef EA_DF_EN
      r_df        <= '0;
      r_mem_field <= '0;
      r_ea_field  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_auto      <= w_auto_nxt;
      r_req       <= w_req_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_ea        <= w_ea_nxt;
      r_valid     <= w_valid_nxt;
`ifdef EA_DF_EN
      r_df        <= w_df_nxt;
      r_mem_field <= w_mem_field_nxt;
      r_ea_field  <= w_ea_field_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_auto_nxt  = r_auto;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_ea_nxt    = r_ea;
    w_valid_nxt = 1'b0;
`ifdef EA_DF_EN
    w_df_nxt        = r_df;
    w_mem_field_nxt = r_mem_field;
    w_ea_field_nxt  = r_ea_field;
`endif

    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_auto_nxt = i_ppind;
`ifdef EA_DF_EN
          w_df_nxt        = i_df_in;
          w_mem_field_nxt = i_if_in;
`endif
          if (i_ppind || i_ind) begin
            w_state_nxt = RD_PTR;
            w_req_nxt   = 1'b1;
            w_we_nxt    = 1'b0;
            w_addr_nxt  = w_pa;
          end else begin
            w_state_nxt = DONE;
            w_ea_nxt    = w_pa;
            w_valid_nxt = 1'b1;
`ifdef EA_DF_EN
            w_ea_field_nxt = i_if_in;
`endif
          end
        end
      end

      RD_PTR: begin
        if (i_mem_ack) begin
          if (r_auto) begin
            // Request stays up; the write-back of the bumped pointer follows directly.
            w_state_nxt = WR_PTR;
            w_we_nxt    = 1'b1;
            w_wdata_nxt = i_mem_rdata + {{(WORD_W-1){1'b0}}, 1'b1};
          end else begin
            w_state_nxt = DONE;
            w_req_nxt   = 1'b0;
            w_ea_nxt    = i_mem_rdata;
            w_valid_nxt = 1'b1;
`ifdef EA_DF_EN
            w_ea_field_nxt = r_df;
`endif
          end
        end
      end

      WR_PTR: begin
        if (i_mem_ack) begin
          w_state_nxt = DONE;
          w_req_nxt   = 1'b0;
          w_we_nxt    = 1'b0;
          w_ea_nxt    = r_wdata;
          w_valid_nxt = 1'b1;
`ifdef EA_DF_EN
          w_ea_field_nxt = r_df;
`endif
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_mem_req   = r_req;
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_ea        = r_ea;
  assign o_ea_valid  = r_valid;
  assign o_busy      = (r_state == RD_PTR) || (r_state == WR_PTR);
`ifdef EA_DF_EN
  assign o_mem_field = r_mem_field;
  assign o_ea_field  = r_ea_field;
`endif

endmodule

// File: tb/tb_ea_sequencer.sv
// tb/tb_ea_sequencer.sv - directed self-checking bench for ea_sequencer
module tb_ea_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] ir, pcl;
  logic        dir, ind, ppind, mp;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [11:0] ea;
  logic        ea_valid, busy;
`ifdef EA_DF_EN
  logic [2:0]  if_in, df_in, mem_field, ea_field;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_rd = 0;
  int n_wr = 0;
  int v0, r0, w0;

  always #5 clk = ~clk;

  ea_sequencer dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_ir        (ir),
    .i_pclatched (pcl),
    .i_dir       (dir),
    .i_ind       (ind),
    .i_ppind     (ppind),
    .i_mp        (mp),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack),
`ifdef EA_DF_EN
    .i_if_in     (if_in),
    .i_df_in     (df_in),
    .o_mem_field (mem_field),
    .o_ea_field  (ea_field),
`endif
    .o_ea        (ea),
    .o_ea_valid  (ea_valid),
    .o_busy      (busy)
  );

  always @(posedge clk) begin
    if (ea_valid) n_valid++;
    if (mem_req && mem_ack && !mem_we) n_rd++;
    if (mem_req && mem_ack && mem_we) n_wr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [11:0] i_ir, input logic [11:0] i_pc,
                           input logic d, input logic n, input logic p, input logic m);
    ir = i_ir; pcl = i_pc; dir = d; ind = n; ppind = p; mp = m;
  endtask

  // Issue a one-cycle START; returns one cycle after acceptance.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Hold off waits cycles, checking the request is held, then acknowledge with rdata.
  task automatic mem_reply(input string tag, input int waits, input logic we,
                           input logic [11:0] addr, input logic [11:0] rdata);
    for (int i = 0; i < waits; i++) begin
      check_eq({tag, "_req_held"}, mem_req, 1'b1);
      step();
    end
    check_eq({tag, "_req"}, mem_req, 1'b1);
    check_eq({tag, "_we"}, mem_we, we);
    check_eq({tag, "_addr"}, mem_addr, addr);
    mem_rdata = rdata;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    mem_rdata = 12'o0000;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    set_instr(12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef EA_DF_EN
    if_in = 3'd0; df_in = 3'd0;
`endif
    step(); step();
    check_eq("rst_req", mem_req, 1'b0);
    check_eq("rst_we", mem_we, 1'b0);
    check_eq("rst_addr", mem_addr, 12'o0000);
    check_eq("rst_wdata", mem_wdata, 12'o0000);
    check_eq("rst_ea", ea, 12'o0000);
    check_eq("rst_valid", ea_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step();

    // Direct, page zero.
    set_instr(12'o0005, 12'o1234, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef EA_DF_EN
    if_in = 3'd5; df_in = 3'd2;
`endif
    pulse_start();
    check_eq("dz_valid", ea_valid, 1'b1);
    check_eq("dz_ea", ea, 12'o0005);
    check_eq("dz_req", mem_req, 1'b0);
    check_eq("dz_busy", busy, 1'b0);
`ifdef EA_DF_EN
    check_eq("dz_eafield", ea_field, 3'd5);
`endif
    step();
    check_eq("dz_valid_off", ea_valid, 1'b0);

    // Direct, current page.
    set_instr(12'o0225, 12'o4210, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse_start();
    check_eq("dc_valid", ea_valid, 1'b1);
    check_eq("dc_ea", ea, 12'o4225);
    step();
    check_eq("dc_valid_off", ea_valid, 1'b0);
    check_eq("dc_ea_held", ea, 12'o4225);

    // Indirect through 0040, two wait states.
    r0 = n_rd; w0 = n_wr;
    set_instr(12'o1440, 12'o2000, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef EA_DF_EN
    if_in = 3'd3; df_in = 3'd6;
`endif
    pulse_start();
    check_eq("in_busy", busy, 1'b1);
    check_eq("in_valid_early", ea_valid, 1'b0);
`ifdef EA_DF_EN
    check_eq("in_memfield", mem_field, 3'd3);
`endif
    mem_reply("in_rd", 2, 1'b0, 12'o0040, 12'o3456);
    check_eq("in_valid", ea_valid, 1'b1);
    check_eq("in_ea", ea, 12'o3456);
    check_eq("in_req_drop", mem_req, 1'b0);
    check_eq("in_busy_drop", busy, 1'b0);
`ifdef EA_DF_EN
    check_eq("in_eafield", ea_field, 3'd6);
`endif
    step();
    check_eq("in_reads", n_rd - r0, 1);
    check_eq("in_writes", n_wr - w0, 0);

    // Auto-index through 0012 holding 7777: wraps to 0000.
    set_instr(12'o1412, 12'o2000, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    mem_reply("ai_rd", 0, 1'b0, 12'o0012, 12'o7777);
    check_eq("ai_wr_wdata", mem_wdata, 12'o0000);
    check_eq("ai_wr_busy", busy, 1'b1);
    check_eq("ai_no_valid", ea_valid, 1'b0);
    mem_reply("ai_wr", 1, 1'b1, 12'o0012, 12'o0000);
    check_eq("ai_valid", ea_valid, 1'b1);
    check_eq("ai_ea", ea, 12'o0000);
    check_eq("ai_req_drop", mem_req, 1'b0);
    check_eq("ai_we_drop", mem_we, 1'b0);
    step();

    // Auto-index through 0017 holding 1234.
    set_instr(12'o1417, 12'o2000, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    mem_reply("ai2_rd", 1, 1'b0, 12'o0017, 12'o1234);
    check_eq("ai2_wdata", mem_wdata, 12'o1235);
    mem_reply("ai2_wr", 0, 1'b1, 12'o0017, 12'o0000);
    check_eq("ai2_ea", ea, 12'o1235);
    step();

    // Reset while the write-back is pending.
    set_instr(12'o1413, 12'o2000, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_start();
    mem_reply("ar_rd", 0, 1'b0, 12'o0013, 12'o0100);
    check_eq("ar_in_wr", mem_we, 1'b1);
    v0 = n_valid;
    #2 rst = 1'b1;
    #1;
    check_eq("ar_req", mem_req, 1'b0);
    check_eq("ar_busy", busy, 1'b0);
    check_eq("ar_we", mem_we, 1'b0);
    check_eq("ar_ea", ea, 12'o0000);
    step();
    rst = 1'b0;
    step(); step();
    check_eq("ar_no_stale", n_valid - v0, 0);
    set_instr(12'o0033, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    check_eq("ar_next_valid", ea_valid, 1'b1);
    check_eq("ar_next_ea", ea, 12'o0033);
    step();

    // START while busy and spurious ACK while idle are both ignored.
    v0 = n_valid;
    set_instr(12'o1477, 12'o0000, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_start();
    set_instr(12'o0011, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_start();
    check_eq("bz_addr_kept", mem_addr, 12'o0077);
    check_eq("bz_still_busy", busy, 1'b1);
    mem_reply("bz_rd", 0, 1'b0, 12'o0077, 12'o5432);
    check_eq("bz_ea", ea, 12'o5432);
    step();
    mem_ack = 1'b1;
    step(); step();
    mem_ack = 1'b0;
    check_eq("sp_req", mem_req, 1'b0);
    check_eq("sp_ea_kept", ea, 12'o5432);
    check_eq("sp_valid", ea_valid, 1'b0);
    step();
    check_eq("bz_one_valid", n_valid - v0, 1);

    // START held across the DONE cycle is only taken once.
    v0 = n_valid;
    set_instr(12'o0044, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    check_eq("hd_valid", ea_valid, 1'b1);
    step();
    start = 1'b0;
    check_eq("hd_done_ignored", ea_valid, 1'b0);
    step();
    check_eq("hd_one_valid", n_valid - v0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
